// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Run-time loadable instruction memory for the MIPS pipeline. A byte-stream
// loader (UART/debug side) fills the memory with big-endian 32-bit words while
// load_mode is high; the IF stage then fetches words through a registered,
// stallable read port. Fetches at or beyond the loaded image return a NOP (0).
//
// Parameters:
//   DEPTH    - number of 32-bit words stored
//   ADDR_BIT - word address width (DEPTH <= 2**ADDR_BIT)
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous active-high reset
//   load_mode     - level: 1 requests loading, 0 requests run
//   ld_byte_valid - loader byte strobe
//   ld_byte       - loader data byte (first byte of a word is bits [31:24])
//   ld_byte_ready - a byte is accepted this cycle if ld_byte_valid is high
//   ld_done       - one-cycle pulse when a load terminates
//   words_loaded  - number of valid words in the current image
//   inst_addr     - word address from the PC
//   stall         - hazard-unit stall, holds the fetched word
//   instruction   - fetched instruction word (1 cycle latency)
//   inst_valid    - instruction is meaningful
//   load_sum      - modulo-2**32 sum of the loaded words
//
// Optional feature macro: INST_MEM_CHECKSUM_EN
//   defined   - load_sum accumulates every word written during a load
//   undefined - load_sum is tied to 0 and no adder is built
// ---------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int DEPTH    = 256,
  parameter int ADDR_BIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_mode,
  input  logic                ld_byte_valid,
  input  logic [7:0]          ld_byte,
  output logic                ld_byte_ready,
  output logic                ld_done,
  output logic [ADDR_BIT:0]   words_loaded,
  input  logic [ADDR_BIT-1:0] inst_addr,
  input  logic                stall,
  output logic [31:0]         instruction,
  output logic                inst_valid,
  output logic [31:0]         load_sum
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BIT-1:0] LAST_PTR = ADDR_BIT'(DEPTH - 1);
  localparam logic [ADDR_BIT:0]   DEPTH_W  = (ADDR_BIT + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                load_mode_q;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         byte_buf_q, byte_buf_d;
  logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT:0]   words_q, words_d;
  logic                ld_done_q, ld_done_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_q, valid_d;

  logic [31:0]         mem_q [DEPTH];

  logic                byte_accept;
  logic                word_write;
  logic                last_word;
  logic                enter_load;
  logic                addr_hit;
  logic [31:0]         wr_word;
  logic [31:0]         rd_word;

  // Byte acceptance and word assembly. The first three bytes of a word sit
  // in byte_buf_q; the fourth byte completes the word on the same edge.
  always_comb begin
    byte_accept = (state_q == LOAD) && ld_byte_valid;
    word_write  = byte_accept && (byte_cnt_q == 2'd3);
    last_word   = word_write && (wr_ptr_q == LAST_PTR);
    wr_word     = {byte_buf_q, ld_byte};
  end

  // State transitions. Leaving LOAD on a full memory does not look at
  // load_mode, and RUN only re-enters LOAD on a rising edge of load_mode,
  // so a level left high after a full load cannot restart loading.
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    ld_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_mode) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (last_word || !load_mode) begin
          state_d   = RUN;
          ld_done_d = 1'b1;
        end
      end
      RUN: begin
        if (load_mode && !load_mode_q) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Loader datapath next state. A word completing on the exit cycle is
  // still counted; any partial word left behind at exit is dropped.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    byte_buf_d = byte_buf_q;
    wr_ptr_d   = wr_ptr_q;
    words_d    = words_q;
    if (enter_load) begin
      byte_cnt_d = 2'd0;
      byte_buf_d = 24'h0;
      wr_ptr_d   = '0;
      words_d    = '0;
    end else if (state_q == LOAD) begin
      if (byte_accept) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        byte_buf_d = {byte_buf_q[15:0], ld_byte};
      end
      if (word_write) begin
        wr_ptr_d = wr_ptr_q + ADDR_BIT'(1);
        words_d  = words_q + (ADDR_BIT + 1)'(1);
      end
      if (state_d != LOAD) begin
        byte_cnt_d = 2'd0;
      end
    end
  end

  // Fetch port. Addresses outside the loaded image (including anything at
  // or past DEPTH) read as a NOP rather than stale memory contents.
  always_comb begin
    addr_hit = ({1'b0, inst_addr} < words_q) && ({1'b0, inst_addr} < DEPTH_W);
    rd_word  = mem_q[inst_addr[IDX_W-1:0]];
    instr_d  = instr_q;
    valid_d  = valid_q;
    if (enter_load || (state_q == LOAD)) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else if ((state_q == RUN) && !stall) begin
      instr_d = addr_hit ? rd_word : 32'h0;
      valid_d = 1'b1;
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_mode_q <= 1'b0;
      byte_cnt_q  <= 2'd0;
      byte_buf_q  <= 24'h0;
      wr_ptr_q    <= '0;
      words_q     <= '0;
      ld_done_q   <= 1'b0;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_mode_q <= load_mode;
      byte_cnt_q  <= byte_cnt_d;
      byte_buf_q  <= byte_buf_d;
      wr_ptr_q    <= wr_ptr_d;
      words_q     <= words_d;
      ld_done_q   <= ld_done_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  // Storage array is deliberately not reset; words_loaded gates every read.
  always_ff @(posedge clk) begin
    if (!reset && word_write) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_word;
    end
  end

`ifdef INST_MEM_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  // Running image checksum; partial words never reach word_write.
  always_comb begin
    sum_d = sum_q;
    if (enter_load) begin
      sum_d = 32'h0;
    end else if (word_write) begin
      sum_d = sum_q + wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 32'h0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign load_sum = sum_q;
`else
  assign load_sum = 32'h0;
`endif

  assign ld_byte_ready = (state_q == LOAD);
  assign ld_done       = ld_done_q;
  assign words_loaded  = words_q;
  assign instruction   = instr_q;
  assign inst_valid    = valid_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Bench for inst_mem_loader. The main instance (DEPTH=256) is tracked by a
// behavioural image model and compared on every falling edge; a second small
// instance (DEPTH=4, ADDR_BIT=3) covers the memory-full exit and the
// address-beyond-DEPTH rule with literal expectations.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

  localparam int DEPTH = 256;

  // Model phases, named after the behaviour they describe.
  localparam int PH_IDLE    = 0;
  localparam int PH_LOADING = 1;
  localparam int PH_RUNNING = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        lm, bv, stl;
  logic [7:0]  bt, addr;
  logic        ready, done, ivalid;
  logic [8:0]  words;
  logic [31:0] instr, lsum;

  logic        sLm, sBv, sStall;
  logic [7:0]  sBt;
  logic [2:0]  sAddr;
  logic        sReady, sDone, sValid;
  logic [3:0]  sWords;
  logic [31:0] sInstr, sSum;

  int errCount   = 0;
  int checkCount = 0;

  // Behavioural model state
  logic [31:0] mImg [DEPTH];
  logic [7:0]  mPart [$];
  int          mPhase;
  int          mCount;
  logic [31:0] mSum, mInstr;
  logic        mValid, mDone, mPrevLm;
  logic        modelOn = 1'b0;

  always #5 clk = ~clk;

  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_BIT(8)) dut (
    .clk(clk), .reset(reset), .load_mode(lm), .ld_byte_valid(bv),
    .ld_byte(bt), .ld_byte_ready(ready), .ld_done(done),
    .words_loaded(words), .inst_addr(addr), .stall(stl),
    .instruction(instr), .inst_valid(ivalid), .load_sum(lsum)
  );

  inst_mem_loader #(.DEPTH(4), .ADDR_BIT(3)) dutSmall (
    .clk(clk), .reset(reset), .load_mode(sLm), .ld_byte_valid(sBv),
    .ld_byte(sBt), .ld_byte_ready(sReady), .ld_done(sDone),
    .words_loaded(sWords), .inst_addr(sAddr), .stall(sStall),
    .instruction(sInstr), .inst_valid(sValid), .load_sum(sSum)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic v, input logic [7:0] b,
                               input logic [7:0] a, input logic s);
    lm   = l;
    bv   = v;
    bt   = b;
    addr = a;
    stl  = s;
    @(negedge clk);
  endtask

  task automatic modelStartLoad();
    mPhase = PH_LOADING;
    mCount = 0;
    mPart.delete();
    mSum   = 32'h0;
    mInstr = 32'h0;
    mValid = 1'b0;
  endtask

  // Reference model: image array plus a queue of pending bytes.
  always @(posedge clk) begin
    if (reset) begin
      mPhase  = PH_IDLE;
      mInstr  = 32'h0;
      mValid  = 1'b0;
      mDone   = 1'b0;
      mCount  = 0;
      mPart.delete();
      mSum    = 32'h0;
      mPrevLm = 1'b0;
      modelOn = 1'b1;
    end else begin
      mDone = 1'b0;
      case (mPhase)
        PH_IDLE: begin
          if (lm) modelStartLoad();
          else mPhase = PH_RUNNING;
        end
        PH_LOADING: begin
          if (bv) begin
            mPart.push_back(bt);
            if (mPart.size() == 4) begin
              mImg[mCount] = {mPart[0], mPart[1], mPart[2], mPart[3]};
              mSum = mSum + mImg[mCount];
              mCount++;
              mPart.delete();
            end
          end
          if (mCount == DEPTH || !lm) begin
            mPhase = PH_RUNNING;
            mDone  = 1'b1;
            mPart.delete();
          end
        end
        default: begin
          if (lm && !mPrevLm) begin
            modelStartLoad();
          end else if (!stl) begin
            mInstr = (int'(addr) < mCount) ? mImg[addr] : 32'h0;
            mValid = 1'b1;
          end
        end
      endcase
      mPrevLm = lm;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("instruction", instr, mInstr);
      checkOutput("inst_valid", 32'(ivalid), 32'(mValid));
      checkOutput("ld_done", 32'(done), 32'(mDone));
      checkOutput("ld_byte_ready", 32'(ready), 32'(mPhase == PH_LOADING));
      checkOutput("words_loaded", 32'(words), 32'(mCount));
`ifdef INST_MEM_CHECKSUM_EN
      checkOutput("load_sum", lsum, mSum);
`else
      checkOutput("load_sum", lsum, 32'h0);
`endif
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " instruction"}, instr, 32'h0);
    checkOutput({tag, " inst_valid"}, 32'(ivalid), 32'h0);
    checkOutput({tag, " ld_byte_ready"}, 32'(ready), 32'h0);
    checkOutput({tag, " ld_done"}, 32'(done), 32'h0);
    checkOutput({tag, " words_loaded"}, 32'(words), 32'h0);
    checkOutput({tag, " load_sum"}, lsum, 32'h0);
  endtask

  initial begin
    logic [7:0] prog1 [8];
    logic [7:0] prog2 [6];
    logic [7:0] prog3 [8];
    logic       curLm;
    prog1 = '{8'h3C, 8'h01, 8'h61, 8'h65, 8'h34, 8'h21, 8'h61, 8'h65};
    prog2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    prog3 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};

    reset = 1'b1; lm = 1'b0; bv = 1'b0; bt = 8'h0; addr = 8'h0; stl = 1'b0;
    sLm = 1'b0; sBv = 1'b0; sBt = 8'h0; sAddr = 3'd0; sStall = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    // Small instance: stream 20 bytes with load_mode held high.
    sLm = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("small ld_byte_ready", 32'(sReady), 32'(i < 16));
      sBv = 1'b1;
      sBt = 8'(i);
      @(negedge clk);
      checkOutput("small ld_done", 32'(sDone), 32'(i == 15));
    end
    sBv = 1'b0;
    checkOutput("small words_loaded", 32'(sWords), 32'd4);
    sLm = 1'b0; sAddr = 3'd3;
    @(negedge clk);
    checkOutput("small fetch 3", sInstr, 32'h0C0D0E0F);
    sAddr = 3'd4;
    @(negedge clk);
    checkOutput("small fetch 4", sInstr, 32'h0);
    checkOutput("small inst_valid", 32'(sValid), 32'h1);

    // Two-word program, then fetch and stall behaviour.
    applyStimulus(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    foreach (prog1[i]) applyStimulus(1'b1, 1'b1, prog1[i], 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    checkOutput("prog1 ld_done", 32'(done), 32'h1);
    checkOutput("prog1 words_loaded", 32'(words), 32'd2);
    checkOutput("model img0", mImg[0], 32'h3C016165);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b0);
    checkOutput("fetch 0", instr, 32'h3C016165);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd1, 1'b0);
    checkOutput("fetch 1", instr, 32'h34216165);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd2, 1'b0);
    checkOutput("fetch 2", instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b1);
      checkOutput("stall hold", instr, 32'h34216165);
      checkOutput("stall valid", 32'(ivalid), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b0);
    checkOutput("after stall", instr, 32'h3C016165);

    // Partial trailing word is discarded.
    applyStimulus(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    foreach (prog2[i]) applyStimulus(1'b1, 1'b1, prog2[i], 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    checkOutput("prog2 words_loaded", 32'(words), 32'd1);
    checkOutput("model prog2 img0", mImg[0], 32'h11223344);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b0);
    checkOutput("prog2 fetch 0", instr, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd1, 1'b0);
    checkOutput("prog2 fetch 1", instr, 32'h0);

    // load_mode falls on the same cycle as the 4th byte.
    applyStimulus(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA1, 8'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA2, 8'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA3, 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hA4, 8'h0, 1'b0);
    checkOutput("late word ld_done", 32'(done), 32'h1);
    checkOutput("late word words_loaded", 32'(words), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b0);
    checkOutput("late word fetch", instr, 32'hA1A2A3A4);

    // Checksum wraps modulo 2**32.
    applyStimulus(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    foreach (prog3[i]) applyStimulus(1'b1, 1'b1, prog3[i], 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
`ifdef INST_MEM_CHECKSUM_EN
    checkOutput("checksum", lsum, 32'h00000001);
`else
    checkOutput("checksum", lsum, 32'h0);
`endif

    // Reset in the middle of a load abandons the image.
    applyStimulus(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'(8'h50 + i), 8'h0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    checkResetValues("mid-load reset");
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'd0, 1'b0);
    checkOutput("post-reset fetch", instr, 32'h0);
    checkOutput("post-reset valid", 32'(ivalid), 32'h1);

    // Fill the whole memory with load_mode held high; extra bytes ignored.
    applyStimulus(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    for (int i = 0; i < 4 * DEPTH + 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
      if (i == 4 * DEPTH - 1) checkOutput("full ld_done", 32'(done), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    checkOutput("full words_loaded", 32'(words), 32'd256);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 8'h0, 8'($urandom), 1'b0);

    // Randomised traffic with occasional mode flips and resets.
    curLm = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 3) curLm = ~curLm;
      reset = ($urandom_range(999) < 3);
      applyStimulus(curLm, 1'($urandom_range(99) < 70), 8'($urandom),
                    ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(15)),
                    1'($urandom_range(99) < 25));
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
